// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types, widths and control/status bit positions
// for the bit-serial adder tile.
package serial_adder_pkg;

    localparam int SA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] UIO_OE_MASK = 8'b0111_0000;

    localparam int LOAD_A_BIT = 0;
    localparam int LOAD_B_BIT = 1;
    localparam int START_BIT  = 2;
    localparam int BUSY_BIT   = 4;
    localparam int DONE_BIT   = 5;
    localparam int COUT_BIT   = 6;

endpackage

// File: rtl/half_adder.sv
// half_adder: single-bit half adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_full_adder.sv
// serial_full_adder: combinational full adder built from two half adders
// and an OR of their carries.
module serial_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1, c1, c2;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

    assign cout = c1 | c2;

endmodule

// File: rtl/tt_um_chandrakanth_serial_adder.sv
// tt_um_chandrakanth_serial_adder: loads two operand bytes, then adds them
// LSB-first over WIDTH cycles through a single full-adder cell.
module tt_um_chandrakanth_serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]   ssr_q, ssr_d, sum_q, sum_d;
    logic               carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               s, c;

    wire load_a = uio_in[LOAD_A_BIT];
    wire load_b = uio_in[LOAD_B_BIT];
    wire start  = uio_in[START_BIT];
    wire unused_ok = &{1'b0, uio_in[7:3]};

    serial_full_adder u_fa (
        .a   (sa_q[0]),
        .b   (sb_q[0]),
        .cin (carry_q),
        .s   (s),
        .cout(c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ssr_d   = ssr_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        if (ena) begin
            if (state_q == RUN) begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                ssr_d   = {s, ssr_q[WIDTH-1:1]};
                carry_d = c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = {s, ssr_q[WIDTH-1:1]};
                    cout_d  = c;
                    state_d = DONE;
                end
            end else begin
                // start launches with the operands held before this edge
                a_d = load_a ? ui_in[WIDTH-1:0] : a_q;
                b_d = load_b ? ui_in[WIDTH-1:0] : b_q;
                if (start) begin
                    state_d = RUN;
                    sa_d    = a_q;
                    sb_d    = b_q;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            ssr_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ssr_q   <= ssr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        uio_out           = '0;
        uio_out[BUSY_BIT] = (state_q == RUN);
        uio_out[DONE_BIT] = (state_q == DONE);
        uio_out[COUT_BIT] = cout_q;
    end

    assign uo_out = sum_q;
    assign uio_oe = UIO_OE_MASK;

endmodule
